jtag_user_dr: RTL and testbench

JTAG_USER_DR -- requirements
Module: jtag_user_dr

---
 rtl/jtag_pkg.sv | 15 +
 rtl/jtag_user_dr_if.sv | 33 +++
 rtl/jtag_sync.sv | 35 +++
 rtl/jtag_user_dr.sv | 157 +++++++++++++++
 tb/tb_jtag_user_dr.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared defaults and TAP event encoding for the JTAG user data register.
package jtag_pkg;

    localparam int unsigned DR_WIDTH_DEF    = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // One TAP event acted on per synchronised TCK rise.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CAP  = 2'd1,
        SHF  = 2'd2,
        UPD  = 2'd3
    } tap_evt_e;

endpackage

// File: rtl/jtag_user_dr_if.sv
// User-side bus: capture word in, update word out with valid/ready and sticky flags.
interface jtag_user_dr_if
    import jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DR_WIDTH_DEF
);

    logic [DR_WIDTH-1:0] cap_data;
    logic [DR_WIDTH-1:0] upd_data;
    logic                upd_valid;
    logic                upd_ready;
    logic                overrun;
    logic                len_err;

    modport master (
        input  cap_data,
        input  upd_ready,
        output upd_data,
        output upd_valid,
        output overrun,
        output len_err
    );

    modport slave (
        output cap_data,
        output upd_ready,
        input  upd_data,
        input  upd_valid,
        input  overrun,
        input  len_err
    );

endinterface

// File: rtl/jtag_sync.sv
// Single-bit synchroniser chain with a rising-edge detector on the synchronised output.
module jtag_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    // Shift the raw input into the chain; remember the last synchronised value.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
        prev_d  = chain_q[STAGES-1];
    end

    // Chain and edge-history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign q      = chain_q[STAGES-1];
    assign rise_c = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_user_dr.sv
// JTAG USER data register: TCK is oversampled in the clk_p domain, capture/shift/update
// act on its synchronised rising edge, and updated words are handed off via valid/ready.
module jtag_user_dr
    import jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH    = DR_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           clk_p,
    input  logic           rst_top,
    input  logic           TCK,
    input  logic           TDI,
    input  logic           SEL,
    input  logic           CAPTURE,
    input  logic           SHIFT,
    input  logic           UPDATE,
    input  logic           RESET,
    output logic           TDO,
    jtag_user_dr_if.master usr
);

    localparam int unsigned         CNT_W   = $clog2(DR_WIDTH + 2);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DR_WIDTH + 1);
    localparam logic [CNT_W-1:0]    CNT_LEN = CNT_W'(DR_WIDTH);

    // Bit order of the non-clock JTAG inputs in the synchroniser bank.
    localparam int unsigned I_TDI = 1;
    localparam int unsigned I_SEL = 2;
    localparam int unsigned I_CAP = 3;
    localparam int unsigned I_SHF = 4;
    localparam int unsigned I_UPD = 5;
    localparam int unsigned I_RST = 6;

    logic [6:1] raw_in;
    logic [6:1] syn;
    logic [6:1] ctl_rise_unused;
    logic       tck_sync_unused;
    logic       tck_rise;

    assign raw_in = {RESET, UPDATE, SHIFT, CAPTURE, SEL, TDI};

    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tck (
        .clk    (clk_p),
        .rst_n  (rst_top),
        .d      (TCK),
        .q      (tck_sync_unused),
        .rise_c (tck_rise)
    );

    for (genvar g = 1; g <= 6; g++) begin : g_sync
        jtag_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk_p),
            .rst_n  (rst_top),
            .d      (raw_in[g]),
            .q      (syn[g]),
            .rise_c (ctl_rise_unused[g])
        );
    end

    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic                tdo_q, tdo_d;
    logic [DR_WIDTH-1:0] upd_data_q, upd_data_d;
    logic                upd_valid_q, upd_valid_d;
    logic                overrun_q, overrun_d;
    logic                len_err_q, len_err_d;
    logic                accept_c;
    tap_evt_e            evt_c;

    // Decode the TAP event on this TCK rise; anything without SEL is ignored.
    always_comb begin
        evt_c = NONE;
        if (tck_rise && syn[I_SEL]) begin
            if (syn[I_CAP])      evt_c = CAP;
            else if (syn[I_SHF]) evt_c = SHF;
            else if (syn[I_UPD]) evt_c = UPD;
        end
    end

    // Next-state for the scan register, bit counter, handoff and sticky flags.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        tdo_d       = sr_q[0];
        upd_data_d  = upd_data_q;
        upd_valid_d = upd_valid_q;
        overrun_d   = overrun_q;
        len_err_d   = len_err_q;
        accept_c    = upd_valid_q & usr.upd_ready;

        if (accept_c) upd_valid_d = 1'b0;

        if (syn[I_RST]) begin
            sr_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
            len_err_d = 1'b0;
        end else begin
            case (evt_c)
                CAP: begin
                    sr_d    = usr.cap_data;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end
                SHF: begin
                    // Shifting stays frozen after a system reset until a fresh capture.
                    if (armed_q) begin
                        sr_d = {syn[I_TDI], sr_q[DR_WIDTH-1:1]};
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                UPD: begin
                    if (cnt_q != CNT_LEN) len_err_d = 1'b1;
                    if (!upd_valid_q || accept_c) begin
                        upd_data_d  = sr_q;
                        upd_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_p) begin
        if (!rst_top) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            tdo_q       <= 1'b0;
            upd_data_q  <= '0;
            upd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            tdo_q       <= tdo_d;
            upd_data_q  <= upd_data_d;
            upd_valid_q <= upd_valid_d;
            overrun_q   <= overrun_d;
            len_err_q   <= len_err_d;
        end
    end

    assign TDO           = tdo_q;
    assign usr.upd_data  = upd_data_q;
    assign usr.upd_valid = upd_valid_q;
    assign usr.overrun   = overrun_q;
    assign usr.len_err   = len_err_q;

endmodule

// File: tb/tb_jtag_user_dr.sv
// Randomised bench for jtag_user_dr against a bit-queue model of the user data register.
module tb_jtag_user_dr;

    logic clk_p = 1'b0;
    logic rst_top, TCK, TDI, SEL, CAPTURE, SHIFT, UPDATE, RESET, TDO;

    jtag_user_dr_if #(.DR_WIDTH(32)) u_if ();

    jtag_user_dr #(.DR_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk_p   (clk_p),
        .rst_top (rst_top),
        .TCK     (TCK),
        .TDI     (TDI),
        .SEL     (SEL),
        .CAPTURE (CAPTURE),
        .SHIFT   (SHIFT),
        .UPDATE  (UPDATE),
        .RESET   (RESET),
        .TDO     (TDO),
        .usr     (u_if)
    );

    always #5 clk_p = ~clk_p;

    int checks = 0;
    int errors = 0;

    // Model: queue front is the bit currently on TDO, back is the newest TDI bit.
    bit          q[$];
    int          m_cnt;
    bit          m_valid, m_overrun, m_len_err;
    logic [31:0] m_data;
    logic [31:0] cap_val;

    task automatic model_clear_sr();
        q.delete();
        repeat (32) q.push_back(1'b0);
        m_cnt = 0;
    endtask

    function automatic logic [31:0] q_word();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = q[i];
        return w;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    // One TCK period: controls set while TCK low, TDO checked just before the rise.
    task automatic jtag_cycle(input bit sel, input bit cap, input bit shf, input bit upd,
                              input bit tdi, input bit ready_at_rise = 1'b0);
        TCK = 1'b0; SEL = sel; CAPTURE = cap; SHIFT = shf; UPDATE = upd; TDI = tdi;
        wait_clks(6);
        checks++;
        if (TDO !== q[0]) begin
            errors++;
            $display("FAIL tdo: got %0b expected %0b (cnt %0d)", TDO, q[0], m_cnt);
        end
        TCK = 1'b1;
        if (ready_at_rise) begin
            wait_clks(2);
            u_if.upd_ready = 1'b1;
            wait_clks(1);
            u_if.upd_ready = 1'b0;
            wait_clks(3);
        end else begin
            wait_clks(6);
        end
        if (sel) begin
            if (cap) begin
                q.delete();
                for (int i = 0; i < 32; i++) q.push_back(cap_val[i]);
                m_cnt = 0;
            end else if (shf) begin
                void'(q.pop_front());
                q.push_back(tdi);
                m_cnt = (m_cnt < 33) ? m_cnt + 1 : 33;
            end else if (upd) begin
                if (m_cnt != 32) m_len_err = 1'b1;
                if (!m_valid || ready_at_rise) begin
                    m_data  = q_word();
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        jtag_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic full_scan(input logic [31:0] cap, input logic [31:0] din, input int nshift,
                             input bit ready_at_rise = 1'b0);
        cap_val = cap;
        u_if.cap_data = cap;
        jtag_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nshift; i++) jtag_cycle(1'b1, 1'b0, 1'b1, 1'b0, din[i % 32]);
        jtag_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ready_at_rise);
        idle();
    endtask

    task automatic do_accept();
        @(negedge clk_p);
        u_if.upd_ready = 1'b1;
        @(negedge clk_p);
        u_if.upd_ready = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (u_if.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clear: upd_valid got %0b expected 0", u_if.upd_valid);
        end
    endtask

    task automatic tap_reset();
        TCK = 1'b0; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; RESET = 1'b1;
        wait_clks(6);
        RESET = 1'b0;
        wait_clks(6);
        model_clear_sr();
        m_overrun = 1'b0;
        m_len_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_top = 1'b0;
        TCK = 1'b0; TDI = 1'b0; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; RESET = 1'b0;
        u_if.cap_data = '0;
        u_if.upd_ready = 1'b0;
        model_clear_sr();
        m_valid = 1'b0; m_overrun = 1'b0; m_len_err = 1'b0; m_data = '0;
        wait_clks(4);
        checks += 5;
        if (TDO !== 1'b0)            begin errors++; $display("FAIL reset_tdo: got %0b expected 0", TDO); end
        if (u_if.upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", u_if.upd_valid); end
        if (u_if.upd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", u_if.upd_data); end
        if (u_if.overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %0b expected 0", u_if.overrun); end
        if (u_if.len_err !== 1'b0)   begin errors++; $display("FAIL reset_len_err: got %0b expected 0", u_if.len_err); end
        rst_top = 1'b1;
        wait_clks(2);
    endtask

    task automatic test_tdo_sequence();
        full_scan(32'hA5A5_0F0F, 32'h0, 32);
        checks += 3;
        if (u_if.len_err !== 1'b0)   begin errors++; $display("FAIL seq_len_err: got %0b expected 0", u_if.len_err); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %0b expected 1", u_if.upd_valid); end
        if (u_if.upd_data !== m_data) begin errors++; $display("FAIL seq_data: got %h expected %h", u_if.upd_data, m_data); end
        do_accept();
    endtask

    task automatic test_shift_update();
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w = (k == 0) ? 32'h1234_5678 : $urandom;
            full_scan($urandom, w, 32);
            checks += 2;
            if (u_if.upd_data !== w || m_data !== w) begin
                errors++; $display("FAIL upd_data: got %h expected %h", u_if.upd_data, w);
            end
            if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL upd_valid: got %0b expected 1", u_if.upd_valid); end
            wait_clks(20);
            checks++;
            if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL upd_valid_hold: got %0b expected 1", u_if.upd_valid); end
            do_accept();
        end
    endtask

    task automatic test_overrun();
        logic [31:0] a, b;
        a = $urandom; b = ~a;
        full_scan($urandom, a, 32);
        full_scan($urandom, b, 32);
        checks += 3;
        if (u_if.overrun !== m_overrun) begin errors++; $display("FAIL overrun: got %0b expected %0b", u_if.overrun, m_overrun); end
        if (u_if.upd_data !== a) begin errors++; $display("FAIL overrun_data: got %h expected %h", u_if.upd_data, a); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %0b expected 1", u_if.upd_valid); end
        tap_reset();
        checks += 4;
        if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL tapreset_overrun: got %0b expected 0", u_if.overrun); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL tapreset_valid: got %0b expected 1", u_if.upd_valid); end
        if (u_if.upd_data !== a) begin errors++; $display("FAIL tapreset_data: got %h expected %h", u_if.upd_data, a); end
        if (TDO !== 1'b0) begin errors++; $display("FAIL tapreset_tdo: got %0b expected 0", TDO); end
        do_accept();
    endtask

    task automatic test_same_cycle_accept();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        full_scan($urandom, a, 32);
        full_scan($urandom, b, 32, 1'b1);
        checks += 3;
        if (u_if.upd_data !== m_data) begin errors++; $display("FAIL same_cycle_data: got %h expected %h", u_if.upd_data, m_data); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_valid: got %0b expected 1", u_if.upd_valid); end
        if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL same_cycle_overrun: got %0b expected 0", u_if.overrun); end
        do_accept();
    endtask

    task automatic test_len_err();
        full_scan($urandom, $urandom, 31);
        checks += 3;
        if (u_if.len_err !== 1'b1) begin errors++; $display("FAIL len31_err: got %0b expected 1", u_if.len_err); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL len31_valid: got %0b expected 1", u_if.upd_valid); end
        if (u_if.upd_data !== m_data) begin errors++; $display("FAIL len31_data: got %h expected %h", u_if.upd_data, m_data); end
        do_accept();
        tap_reset();
        checks++;
        if (u_if.len_err !== 1'b0) begin errors++; $display("FAIL len_clear: got %0b expected 0", u_if.len_err); end
        full_scan($urandom, $urandom, 33);
        checks += 2;
        if (u_if.len_err !== 1'b1) begin errors++; $display("FAIL len33_err: got %0b expected 1", u_if.len_err); end
        if (u_if.upd_data !== m_data) begin errors++; $display("FAIL len33_data: got %h expected %h", u_if.upd_data, m_data); end
        do_accept();
        tap_reset();
    endtask

    task automatic test_midscan_reset();
        logic [31:0] w;
        full_scan($urandom, 32'hDEAD_BEEF, 31);
        full_scan($urandom, $urandom, 32);
        cap_val = 32'hFFFF_FFFF;
        u_if.cap_data = cap_val;
        jtag_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) jtag_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom));
        wait_clks(1);
        rst_top = 1'b0;
        TCK = 1'b0; SEL = 1'b0; SHIFT = 1'b0;
        wait_clks(1);
        model_clear_sr();
        m_valid = 1'b0; m_overrun = 1'b0; m_len_err = 1'b0; m_data = '0;
        checks += 5;
        if (TDO !== 1'b0)            begin errors++; $display("FAIL midrst_tdo: got %0b expected 0", TDO); end
        if (u_if.upd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", u_if.upd_valid); end
        if (u_if.upd_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", u_if.upd_data); end
        if (u_if.overrun !== 1'b0)   begin errors++; $display("FAIL midrst_overrun: got %0b expected 0", u_if.overrun); end
        if (u_if.len_err !== 1'b0)   begin errors++; $display("FAIL midrst_len_err: got %0b expected 0", u_if.len_err); end
        rst_top = 1'b1;
        wait_clks(2);
        w = $urandom;
        full_scan($urandom, w, 32);
        checks += 3;
        if (u_if.upd_data !== w) begin errors++; $display("FAIL post_rst_data: got %h expected %h", u_if.upd_data, w); end
        if (u_if.upd_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %0b expected 1", u_if.upd_valid); end
        if (u_if.len_err !== 1'b0) begin errors++; $display("FAIL post_rst_len_err: got %0b expected 0", u_if.len_err); end
        do_accept();
    endtask

    task automatic test_sel_low();
        logic [31:0] w;
        w = $urandom;
        cap_val = $urandom;
        u_if.cap_data = cap_val;
        jtag_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) jtag_cycle(1'b1, 1'b0, 1'b1, 1'b0, w[i]);
        for (int i = 0; i < 8; i++) begin
            u_if.cap_data = $urandom;
            jtag_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        jtag_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (u_if.upd_valid !== 1'b0) begin errors++; $display("FAIL sel_low_valid: got %0b expected 0", u_if.upd_valid); end
        for (int i = 16; i < 32; i++) jtag_cycle(1'b1, 1'b0, 1'b1, 1'b0, w[i]);
        jtag_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        checks += 2;
        if (u_if.upd_data !== w) begin errors++; $display("FAIL sel_low_data: got %h expected %h", u_if.upd_data, w); end
        if (u_if.len_err !== 1'b0) begin errors++; $display("FAIL sel_low_len_err: got %0b expected 0", u_if.len_err); end
        do_accept();
    endtask

    initial begin
        test_reset();
        test_tdo_sequence();
        test_shift_update();
        test_overrun();
        test_same_cycle_accept();
        test_len_err();
        test_midscan_reset();
        test_sel_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
